// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default framing constants
// used by uart_tx, uart_rx and baud_generator.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned FRAME_BITS_DEF = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: oversample tick and serial line in, recovered byte and
// status strobes out. master = receiver, slave = the logic feeding/consuming it.
interface uart_rx_if #(
  parameter int unsigned FRAME_BITS = uart_pkg::FRAME_BITS_DEF
) ();

  logic                  baud_tick;
  logic                  rx_in;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_busy;
  logic                  frame_error;
  logic                  parity_error;

  modport master (
    input  baud_tick,
    input  rx_in,
    output rx_data,
    output rx_valid,
    output rx_busy,
    output frame_error,
    output parity_error
  );

  modport slave (
    output baud_tick,
    output rx_in,
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  frame_error,
    input  parity_error
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// configurable reset value so idle-high lines do not glitch out of reset.
module sync_2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= ResetVal;
      q      <= ResetVal;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/stop framing, LSB first, one-clk strobes.
// Optional parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int unsigned PARITY_ODD = 0
) (
  input logic       clk,
  input logic       reset,
  uart_rx_if.master bus
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(FRAME_BITS + 1);

  localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(FRAME_BITS - 1);

  rx_state_t             state_q, state_d;
  logic [CntW-1:0]       sample_cnt_q, sample_cnt_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  busy_q;
  logic                  rx_s;

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  logic par_bad_q, par_bad_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD[0];
`endif

  sync_2ff #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (bus.rx_in),
    .q    (rx_s)
  );

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    ferr_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d       = 1'b0;
    par_bad_d    = par_bad_q;
`endif
    if (bus.baud_tick) begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_d      = StStart;
            sample_cnt_d = '0;
          end
        end
        StStart: begin
          // Re-check the line mid start bit; a high level here was a glitch.
          if (sample_cnt_q == CntHalf) begin
            if (rx_s) begin
              state_d = StIdle;
            end else begin
              state_d      = StData;
              sample_cnt_d = '0;
              bit_cnt_d    = '0;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
        StData: begin
          if (sample_cnt_q == CntLast) begin
            shift_d      = {rx_s, shift_q[FRAME_BITS-1:1]};
            sample_cnt_d = '0;
            bit_cnt_d    = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
        StParity: begin
`ifdef UART_RX_PARITY_EN
          if (sample_cnt_q == CntLast) begin
            par_bad_d    = rx_s != ((^shift_q) ^ PARITY_ODD[0]);
            sample_cnt_d = '0;
            state_d      = StStop;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
`else
          state_d = StIdle;
`endif
        end
        StStop: begin
          // Leave at mid-stop so the next start edge is never missed.
          if (sample_cnt_q == CntLast) begin
            state_d = StIdle;
            if (!rx_s) begin
              ferr_d = 1'b1;
            end else begin
`ifdef UART_RX_PARITY_EN
              if (par_bad_q) begin
                perr_d = 1'b1;
              end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
              end
`else
              data_d  = shift_q;
              valid_d = 1'b1;
`endif
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      ferr_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      ferr_q       <= ferr_d;
      busy_q       <= (state_d != StIdle);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
    end
  end

  assign bus.parity_error = perr_q;
`else
  assign bus.parity_error = 1'b0;
`endif

  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.rx_busy     = busy_q;
  assign bus.frame_error = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: bit-banged frames against a frame-level model.
// Honours UART_RX_PARITY_EN to add the parity bit and parity scenarios.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned FB         = FRAME_BITS_DEF;
  localparam int unsigned OS         = OVERSAMPLE_DEF;
  localparam int unsigned PARITY_ODD = 0;
  // Fast tick keeps the run short; the receiver only ever counts ticks.
  localparam int unsigned TickDiv    = 8;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned div_cnt = 0;

  uart_rx_if #(.FRAME_BITS(FB)) bus ();

  uart_rx #(
    .FRAME_BITS(FB),
    .OVERSAMPLE(OS),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (div_cnt == TickDiv - 1) begin
      div_cnt       <= 0;
      bus.baud_tick <= 1'b1;
    end else begin
      div_cnt       <= div_cnt + 1;
      bus.baud_tick <= 1'b0;
    end
  end

  // Observed strobes
  logic [FB-1:0] got_q[$];
  int            n_valid = 0, n_ferr = 0, n_perr = 0;
  int            n_overlap = 0, n_wide = 0, n_busy_fall = 0;
  logic          prev_valid = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      got_q.push_back(bus.rx_data);
      n_valid <= n_valid + 1;
    end
    if (bus.frame_error === 1'b1) n_ferr <= n_ferr + 1;
    if (bus.parity_error === 1'b1) n_perr <= n_perr + 1;
    if (bus.rx_valid === 1'b1 && bus.frame_error === 1'b1) n_overlap <= n_overlap + 1;
    if (prev_valid && bus.rx_valid === 1'b1) n_wide <= n_wide + 1;
    if (prev_busy && bus.rx_busy === 1'b0) n_busy_fall <= n_busy_fall + 1;
    prev_valid <= (bus.rx_valid === 1'b1);
    prev_busy  <= (bus.rx_busy === 1'b1);
  end

  // Frame-level reference model
  logic [FB-1:0] exp_q[$];
  int            exp_ferr = 0, exp_perr = 0;
  logic [FB-1:0] exp_data = '0;
  int            checks = 0, errors = 0;

  function automatic logic good_par(input logic [FB-1:0] d);
    return 1'(($countones(d) + PARITY_ODD) % 2);
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (bus.baud_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic drive_bit(input logic b);
    bus.rx_in = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [FB-1:0] d, input logic stop_b, input logic par_b,
                            input int gap);
    drive_bit(1'b0);
    for (int i = 0; i < FB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b);
`endif
    drive_bit(stop_b);
    bus.rx_in = 1'b1;
    if (gap > 0) wait_ticks(gap);
    else #1;
    if (!stop_b) exp_ferr++;
`ifdef UART_RX_PARITY_EN
    else if (par_b !== good_par(d)) exp_perr++;
`endif
    else begin
      exp_q.push_back(d);
      exp_data = d;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.rx_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (bus.rx_data !== '0) begin errors++;
      $display("FAIL reset_rx_data: got %h expected 00", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++;
      $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
    checks++; if (bus.rx_busy !== 1'b0) begin errors++;
      $display("FAIL reset_rx_busy: got %b expected 0", bus.rx_busy); end
    checks++; if (bus.frame_error !== 1'b0) begin errors++;
      $display("FAIL reset_frame_error: got %b expected 0", bus.frame_error); end
    checks++; if (bus.parity_error !== 1'b0) begin errors++;
      $display("FAIL reset_parity_error: got %b expected 0", bus.parity_error); end
    reset = 1'b0;
    wait_ticks(4);
    checks++; if (bus.rx_busy !== 1'b0) begin errors++;
      $display("FAIL idle_busy: got %b expected 0", bus.rx_busy); end
  endtask

  task automatic test_loopback();
    got_q.delete(); exp_q.delete();
    send_frame(8'h55, 1'b1, good_par(8'h55), OS);
    send_frame(8'hA5, 1'b1, good_par(8'hA5), OS);
    checks++; if (got_q.size() !== 2) begin errors++;
      $display("FAIL loop_count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL loop_byte%0d: got %h expected %h", i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
    checks++; if (n_ferr !== exp_ferr || n_perr !== exp_perr) begin errors++;
      $display("FAIL loop_errors: got ferr=%0d perr=%0d expected %0d %0d",
               n_ferr, n_perr, exp_ferr, exp_perr); end
    checks++; if (bus.rx_data !== exp_data) begin errors++;
      $display("FAIL loop_rx_data: got %h expected %h", bus.rx_data, exp_data); end
  endtask

  task automatic test_back_to_back();
    int falls0;
    got_q.delete(); exp_q.delete();
    falls0 = n_busy_fall;
    send_frame(8'h00, 1'b1, good_par(8'h00), 0);
    send_frame(8'hFF, 1'b1, good_par(8'hFF), 0);
    send_frame(8'h80, 1'b1, good_par(8'h80), OS);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++;
      $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL b2b_byte%0d: got %h expected %h", i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
    checks++; if (n_busy_fall - falls0 !== 3) begin errors++;
      $display("FAIL b2b_busy_drops: got %0d expected 3", n_busy_fall - falls0); end
    checks++; if (n_ferr !== exp_ferr) begin errors++;
      $display("FAIL b2b_ferr: got %0d expected %0d", n_ferr, exp_ferr); end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    bus.rx_in = 1'b0;
    wait_ticks(3);
    checks++; if (bus.rx_busy !== 1'b1) begin errors++;
      $display("FAIL glitch_busy_rise: got %b expected 1", bus.rx_busy); end
    bus.rx_in = 1'b1;
    wait_ticks(OS / 2);
    checks++; if (bus.rx_busy !== 1'b0) begin errors++;
      $display("FAIL glitch_busy_fall: got %b expected 0", bus.rx_busy); end
    wait_ticks(OS);
    checks++; if (n_valid !== v0 || n_ferr !== f0) begin errors++;
      $display("FAIL glitch_strobes: got valid=%0d ferr=%0d expected 0 0",
               n_valid - v0, n_ferr - f0); end
  endtask

  task automatic test_framing();
    int v0;
    logic [FB-1:0] held;
    got_q.delete(); exp_q.delete();
    v0   = n_valid;
    held = exp_data;
    send_frame(8'h3C, 1'b0, good_par(8'h3C), OS);
    checks++; if (n_ferr !== exp_ferr) begin errors++;
      $display("FAIL frame_err_count: got %0d expected %0d", n_ferr, exp_ferr); end
    checks++; if (n_valid !== v0) begin errors++;
      $display("FAIL frame_no_valid: got %0d expected 0", n_valid - v0); end
    checks++; if (bus.rx_data !== held) begin errors++;
      $display("FAIL frame_data_held: got %h expected %h", bus.rx_data, held); end
    send_frame(8'h3C, 1'b1, good_par(8'h3C), OS);
    checks++; if (got_q.size() !== 1 || got_q[0] !== 8'h3C) begin errors++;
      $display("FAIL frame_recover: got %0d bytes first=%h expected 1 byte 3c",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_reset_mid_frame();
    int v0, f0;
    logic [FB-1:0] d;
    d = 8'hC3;
    got_q.delete(); exp_q.delete();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    bus.rx_in = d[4];
    wait_ticks(OS / 2);
    v0 = n_valid; f0 = n_ferr;
    reset     = 1'b1;
    bus.rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_data = '0;
    checks++; if (bus.rx_busy !== 1'b0 || bus.rx_valid !== 1'b0 || bus.rx_data !== '0 ||
                  bus.frame_error !== 1'b0 || bus.parity_error !== 1'b0) begin errors++;
      $display("FAIL midreset_outputs: got busy=%b valid=%b data=%h ferr=%b perr=%b expected all 0",
               bus.rx_busy, bus.rx_valid, bus.rx_data, bus.frame_error, bus.parity_error); end
    reset = 1'b0;
    wait_ticks(2 * OS * (FB + 2));
    checks++; if (n_valid !== v0 || n_ferr !== f0) begin errors++;
      $display("FAIL midreset_strobes: got valid=%0d ferr=%0d expected 0 0",
               n_valid - v0, n_ferr - f0); end
    send_frame(d, 1'b1, good_par(d), OS);
    checks++; if (got_q.size() !== 1 || bus.rx_data !== 8'hC3) begin errors++;
      $display("FAIL midreset_next: got %0d bytes data=%h expected 1 byte c3",
               got_q.size(), bus.rx_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [FB-1:0] held;
    got_q.delete(); exp_q.delete();
    held = exp_data;
    send_frame(8'h07, 1'b1, 1'b0, OS);
    checks++; if (n_perr !== exp_perr) begin errors++;
      $display("FAIL parity_err_count: got %0d expected %0d", n_perr, exp_perr); end
    checks++; if (got_q.size() !== 0 || bus.rx_data !== held) begin errors++;
      $display("FAIL parity_no_valid: got %0d bytes data=%h expected 0 bytes %h",
               got_q.size(), bus.rx_data, held); end
    send_frame(8'h07, 1'b1, 1'b1, OS);
    checks++; if (got_q.size() !== 1 || bus.rx_data !== 8'h07) begin errors++;
      $display("FAIL parity_good: got %0d bytes data=%h expected 1 byte 07",
               got_q.size(), bus.rx_data); end
    send_frame(8'h07, 1'b0, 1'b0, OS);
    checks++; if (n_perr !== exp_perr || n_ferr !== exp_ferr) begin errors++;
      $display("FAIL parity_ferr_wins: got perr=%0d ferr=%0d expected %0d %0d",
               n_perr, n_ferr, exp_perr, exp_ferr); end
  endtask
`endif

  task automatic test_random();
    logic [FB-1:0] d;
    logic          stop_b, par_b;
    int            gap;
    got_q.delete(); exp_q.delete();
    for (int n = 0; n < 8; n++) begin
      d      = FB'($urandom);
      stop_b = ($urandom_range(0, 4) != 0);
      par_b  = good_par(d) ^ ($urandom_range(0, 3) == 0);
      gap    = stop_b ? int'($urandom_range(0, OS)) : OS;
      send_frame(d, stop_b, par_b, gap);
    end
    wait_ticks(OS);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++;
      $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL rand_byte%0d: got %h expected %h", i,
                 (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); end
    end
    checks++; if (n_ferr !== exp_ferr || n_perr !== exp_perr) begin errors++;
      $display("FAIL rand_errors: got ferr=%0d perr=%0d expected %0d %0d",
               n_ferr, n_perr, exp_ferr, exp_perr); end
    checks++; if (bus.rx_data !== exp_data) begin errors++;
      $display("FAIL rand_rx_data: got %h expected %h", bus.rx_data, exp_data); end
    checks++; if (n_overlap !== 0 || n_wide !== 0) begin errors++;
      $display("FAIL strobe_shape: got overlap=%0d wide=%0d expected 0 0", n_overlap, n_wide); end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_loopback();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
